video_palette: RTL and testbench
================================

VIDEO_PALETTE -- requirements
Module: video_palette

Interface
REQ-001 clk  in  1  master video clock, 28 MHz.
REQ-002 rst  in  1  asynchronous reset, active-high.
REQ-003 c1  in  1  single-clk strobe marking the first half of a 7 MHz pixel slot, once per 4 clk.
REQ-004 c3  in  1  single-clk strobe marking the second half of a slot, 2 clk after c1.
REQ-005 vplex_in  in  8  pixel plex from the render stage; in hires this is {pixel0[3:0], pixel1[3:0]}.
REQ-006 hires  in  1  1 = plex carries two 4-bit pixels per slot.
REQ-007 gpal  in  4  upper palette index bits used in hires.
REQ-008 blank_in, hsync_in, vsync_in  in  1 each  raster timing, active-high, aligned to vplex_in.
REQ-009 cram_we  in  1  palette write strobe, one entry per clk.
REQ-010 cram_addr  in  8  palette write address.
REQ-011 cram_data  in  16  palette write data, {1'b0, R[4:0], G[4:0], B[4:0]}.
REQ-012 vred, vgrn, vblu  out  5 each  colour to the DAC.
REQ-013 hsync_out, vsync_out  out  1 each  sync delayed to match colour latency.

Function
REQ-014 Palette is 256 x 15-bit RAM (bit 15 dropped), synchronous write on clk when cram_we=1, synchronous read with 1-clk latency.
REQ-015 On a clk where c1=1: latch vplex_in, hires, gpal, blank_in, hsync_in, vsync_in into slot registers (cycle N).
REQ-016 Index on c1 slot: hires=0 -> vplex_in[7:0]; hires=1 -> {gpal, vplex_in[7:4]}.
REQ-017 On a clk where c3=1 and the latched hires=1: index = {latched gpal, latched vplex[3:0]}; the latched sync/blank are reused.
REQ-018 On c3 with latched hires=0: no new lookup; output holds.
REQ-019 Pipeline: index registered at N, RAM data at N+1, vred/vgrn/vblu registered at N+2; fixed 2-clk latency from strobe to colour.
REQ-020 Blank latched at the strobe and delayed 2 clk; when set, output colour = 0 regardless of RAM.
REQ-021 hsync_out/vsync_out update at N+2 after c1 only, equal to values latched at c1.
REQ-022 Write and read at the same address on the same clk: read returns the old entry; new entry is visible to the next lookup.
REQ-023 c1 and c3 high on the same clk is illegal; c1 takes priority, c3 ignored.
REQ-024 hires change mid-line takes effect at the next c1; no change within a slot.
REQ-025 Strobes absent: all outputs hold their last value indefinitely.

Reset
REQ-026 rst=1 clears slot registers, index, pipeline, vred/vgrn/vblu=0, hsync_out=vsync_out=0, blank pipeline=1.
REQ-027 Palette RAM contents are not reset; writes during rst are ignored.
REQ-028 After rst release, first valid colour appears 2 clk after the first c1; outputs stay 0 until then.
REQ-029 rst asserted mid-pipeline discards in-flight pixels; no partial colour is output.

Configuration
REQ-030 Macro VPAL_HIRES_EN: defined -> hires behaviour per REQ-016/017; undefined -> hires, gpal and c3 are ignored, index always vplex_in[7:0], one lookup per slot.

Verification
REQ-031 Write cram[0x5A]=0x7C1F, hires=0, vplex_in=0x5A at c1 -> vred=0x1F, vgrn=0x00, vblu=0x1F exactly 2 clk later.
REQ-032 VPAL_HIRES_EN, hires=1, gpal=0x3, vplex_in=0xA5, cram[0x3A]=0x001F, cram[0x35]=0x7C00 -> blue 0x1F at c1+2, red 0x1F at c3+2.
REQ-033 Same-clk write cram[0x10]=0x03E0 while lookup 0x10 (old 0x0000) -> output 0; next slot outputs vgrn=0x1F.
REQ-034 blank_in=1 at c1 with cram entry 0x7FFF -> colour 0 at c1+2; hsync_in=1 at c1 -> hsync_out=1 at c1+2.
REQ-035 Assert rst for 1 clk between c1 and its N+2 -> outputs 0, no stale colour; normal output from next c1+2.
REQ-036 VPAL_HIRES_EN undefined, hires=1, vplex_in=0xA5 -> lookup index 0xA5 only, output unchanged at c3+2.

Source files
------------

// File: rtl/video_palette.sv
// video_palette: 256-entry 15-bit colour lookup between the render stage and
// the DAC. One lookup per pixel slot (at c1); with VPAL_HIRES_EN defined, a
// second lookup at c3 serves the second 4-bit pixel of a hires slot.
// Strobe-to-colour latency is a fixed 2 clk: index at N, RAM data at N+1,
// colour register at N+2. Without VPAL_HIRES_EN, hires/gpal/c3 are ignored.
module video_palette (
    input  logic        clk,
    input  logic        rst,
    input  logic        c1,
    input  logic        c3,
    input  logic [7:0]  vplex_in,
    input  logic        hires,
    input  logic [3:0]  gpal,
    input  logic        blank_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        cram_we,
    input  logic [7:0]  cram_addr,
    input  logic [15:0] cram_data,
    output logic [4:0]  vred,
    output logic [4:0]  vgrn,
    output logic [4:0]  vblu,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam int STAGES = 2;

    // slot registers, captured once per slot on c1
    logic [7:0] plex_q;
    logic       blank_q;
    logic       hsync_q;
    logic       vsync_q;
`ifdef VPAL_HIRES_EN
    logic       hires_q;
    logic [3:0] gpal_q;
`endif

    // lookup request for this clk
    logic       lk_go;
    logic       lk_sync;
    logic [7:0] lk_idx;

    // pipeline state
    logic [STAGES:1] vld_pipe;   // lookup in flight at stage N / N+1
    logic [STAGES:1] sync_pipe;  // lookup came from c1, so sync must update
    logic [7:0]      idx_r;
    logic            blank_s2;
    logic            hsync_s2;
    logic            vsync_s2;

    // palette storage (not reset) and its registered read port
    logic [14:0] mem [256];
    logic [14:0] ram_q;

    // latch the raster inputs for the whole slot on c1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            plex_q  <= '0;
            blank_q <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
`ifdef VPAL_HIRES_EN
            hires_q <= 1'b0;
            gpal_q  <= '0;
`endif
        end else if (c1) begin
            plex_q  <= vplex_in;
            blank_q <= blank_in;
            hsync_q <= hsync_in;
            vsync_q <= vsync_in;
`ifdef VPAL_HIRES_EN
            hires_q <= hires;
            gpal_q  <= gpal;
`endif
        end
    end

    // pick the lookup for this clk; c1 wins over a simultaneous c3
    always_comb begin
        lk_go   = 1'b0;
        lk_sync = 1'b0;
        lk_idx  = '0;
        if (c1) begin
            lk_go   = 1'b1;
            lk_sync = 1'b1;
`ifdef VPAL_HIRES_EN
            lk_idx  = hires ? {gpal, vplex_in[7:4]} : vplex_in;
`else
            lk_idx  = vplex_in;
`endif
        end
`ifdef VPAL_HIRES_EN
        else if (c3 && hires_q) begin
            // second hires pixel: reuses the slot's latched blank and sync
            lk_go  = 1'b1;
            lk_idx = {gpal_q, plex_q[3:0]};
        end
`endif
    end

    // stage N and N+1 control: index, valid, sync-update and blank tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            sync_pipe <= '0;
            idx_r     <= '0;
            blank_s2  <= 1'b1;
            hsync_s2  <= 1'b0;
            vsync_s2  <= 1'b0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], lk_go};
            sync_pipe <= {sync_pipe[STAGES-1:1], lk_sync};
            if (lk_go)
                idx_r <= lk_idx;
            // blank_q/hsync_q/vsync_q already hold this slot's values at N
            blank_s2  <= blank_q;
            hsync_s2  <= hsync_q;
            vsync_s2  <= vsync_q;
        end
    end

    // palette write port and 1-clk read; same-address read returns old data
    always_ff @(posedge clk) begin
        if (cram_we && !rst)
            mem[cram_addr] <= cram_data[14:0];
        ram_q <= mem[idx_r];
    end

    // stage N+2: colour and sync registers, holding when nothing arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vred      <= '0;
            vgrn      <= '0;
            vblu      <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else if (vld_pipe[STAGES]) begin
            if (blank_s2) begin
                vred <= '0;
                vgrn <= '0;
                vblu <= '0;
            end else begin
                vred <= ram_q[14:10];
                vgrn <= ram_q[9:5];
                vblu <= ram_q[4:0];
            end
            if (sync_pipe[STAGES]) begin
                hsync_out <= hsync_s2;
                vsync_out <= vsync_s2;
            end
        end
    end

    // inputs/bits that carry no function in this build
    logic unused_bits;
`ifdef VPAL_HIRES_EN
    assign unused_bits = ^{cram_data[15], plex_q[7:4]};
`else
    assign unused_bits = ^{cram_data[15], plex_q, hires, gpal, c3};
`endif

endmodule

// File: tb/tb_video_palette.sv
// Bench for video_palette: scoreboard of expected colour/sync words, each due
// 2 clk after the strobe that produced it, plus inline checks for reset,
// mid-pipeline reset and idle hold. Works with or without VPAL_HIRES_EN.
module tb_video_palette;

`ifdef VPAL_HIRES_EN
    localparam bit HIRES_EN = 1'b1;
`else
    localparam bit HIRES_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c1 = 1'b0, c3 = 1'b0;
    logic [7:0]  vplex_in = '0;
    logic        hires = 1'b0;
    logic [3:0]  gpal = '0;
    logic        blank_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic        cram_we = 1'b0;
    logic [7:0]  cram_addr = '0;
    logic [15:0] cram_data = '0;
    logic [4:0]  vred, vgrn, vblu;
    logic        hsync_out, vsync_out;

    video_palette dut (
        .clk(clk), .rst(rst), .c1(c1), .c3(c3), .vplex_in(vplex_in),
        .hires(hires), .gpal(gpal), .blank_in(blank_in), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .cram_we(cram_we), .cram_addr(cram_addr),
        .cram_data(cram_data), .vred(vred), .vgrn(vgrn), .vblu(vblu),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // reference model state
    logic [14:0] pal [256];
    logic [14:0] exp_col = '0;
    logic        exp_hs = 1'b0, exp_vs = 1'b0;

    typedef struct {
        int          due;
        logic [16:0] val;
        string       tag;
    } exp_t;
    exp_t sb[$];

    function automatic logic [14:0] col_of(input logic [7:0] idx, input logic blk);
        return blk ? 15'd0 : pal[idx];
    endfunction

    function automatic logic [16:0] dut_word();
        return {vred, vgrn, vblu, hsync_out, vsync_out};
    endfunction

    // called at a negedge where a strobe is driven: result due 2 clk after the edge
    task automatic push(input string tag);
        exp_t e;
        e.due = cyc + 3;
        e.val = {exp_col, exp_hs, exp_vs};
        e.tag = tag;
        sb.push_back(e);
    endtask

    // scoreboard checker
    always @(negedge clk) begin : mon
        exp_t e;
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.due != cyc) begin
                bad++;
                $display("FAIL %s: missed check slot (due %0d, now %0d)", e.tag, e.due, cyc);
            end else if (dut_word() !== e.val) begin
                bad++;
                $display("FAIL %s: got rgbhv=%h want %h", e.tag, dut_word(), e.val);
            end
        end
    end

    task automatic wr(input logic [7:0] a, input logic [14:0] d);
        @(negedge clk);
        cram_we = 1'b1; cram_addr = a; cram_data = {1'b0, d};
        pal[a] = d;
        @(negedge clk);
        cram_we = 1'b0;
    endtask

    // one 4-clk pixel slot: c1, idle, c3 (inputs scrambled to prove latching), idle
    task automatic slot(input logic [7:0] plex, input logic hr, input logic [3:0] gp,
                        input logic blk, input logic hs, input logic vs, input string tag);
        logic hr_eff;
        hr_eff = HIRES_EN && hr;
        @(negedge clk);
        c1 = 1'b1; vplex_in = plex; hires = hr; gpal = gp;
        blank_in = blk; hsync_in = hs; vsync_in = vs;
        exp_col = col_of(hr_eff ? {gp, plex[7:4]} : plex, blk);
        exp_hs = hs; exp_vs = vs;
        push({tag, "/c1"});
        @(negedge clk);
        c1 = 1'b0;
        @(negedge clk);
        c3 = 1'b1; vplex_in = ~plex; hires = ~hr; gpal = ~gp;
        blank_in = ~blk; hsync_in = ~hs; vsync_in = ~vs;
        if (hr_eff) exp_col = col_of({gp, plex[3:0]}, blk);
        push({tag, "/c3"});
        @(negedge clk);
        c3 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            total++; bad++;
            $display("FAIL drain: %0d expectations never checked", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (dut_word() !== 17'd0) begin
            bad++; $display("FAIL reset_state: got %h want 0", dut_word());
        end
        rst = 1'b0;
        for (int i = 0; i < 256; i++) wr(i[7:0], 15'($urandom));
        wr(8'h5A, 15'h7C1F);
        // first lookup after reset: zero until c1+2
        @(negedge clk);
        c1 = 1'b1; vplex_in = 8'h5A; hires = 1'b0; blank_in = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b0;
        exp_col = col_of(8'h5A, 1'b0); exp_hs = 1'b0; exp_vs = 1'b0;
        push("first_5a");
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            c1 = 1'b0;
            total++;
            if (dut_word() !== 17'd0) begin
                bad++; $display("FAIL first_early%0d: got %h want 0", k, dut_word());
            end
        end
        drain();
        total++;
        if ({vred, vgrn, vblu} !== {5'h1F, 5'h00, 5'h1F}) begin
            bad++; $display("FAIL first_rgb: got %h want 7c1f", {vred, vgrn, vblu});
        end
    endtask

    task automatic test_basic();
        slot(8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, "basic00");
        slot(8'hFF, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, "basicff");
        slot(8'h81, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, "basic81");
        slot(8'h5A, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, "basic5a");
        drain();
    endtask

    task automatic test_blank_sync();
        wr(8'h44, 15'h7FFF);
        slot(8'h44, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, "blank_on");
        slot(8'h44, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, "blank_off");
        drain();
    endtask

    task automatic test_same_clk_write();
        wr(8'h10, 15'h0000);
        @(negedge clk);
        c1 = 1'b1; vplex_in = 8'h10; hires = 1'b0; blank_in = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b0;
        exp_col = col_of(8'h10, 1'b0); exp_hs = 1'b0; exp_vs = 1'b0;
        push("rdw_old");
        @(negedge clk);
        c1 = 1'b0;
        // write lands on the clk the RAM reads index 0x10
        cram_we = 1'b1; cram_addr = 8'h10; cram_data = 16'h03E0;
        @(negedge clk);
        cram_we = 1'b0; pal[8'h10] = 15'h03E0;
        c3 = 1'b1;
        push("rdw_hold");
        @(negedge clk);
        c3 = 1'b0;
        slot(8'h10, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, "rdw_new");
        drain();
    endtask

    task automatic test_hires();
        wr(8'h3A, 15'h001F);
        wr(8'h35, 15'h7C00);
        wr(8'hA5, 15'h2A55);
        slot(8'hA5, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, "hires_a5");
        slot(8'hA5, 1'b1, 4'h3, 1'b1, 1'b0, 1'b1, "hires_blank");
        slot(8'hA5, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, "hires_off");
        drain();
    endtask

    task automatic test_mid_reset();
        wr(8'h22, 15'h1234);
        slot(8'hFF, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, "pre_rst");
        drain();
        @(negedge clk);
        c1 = 1'b1; vplex_in = 8'h44; hires = 1'b0; blank_in = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        @(negedge clk);
        c1 = 1'b0; rst = 1'b1;
        cram_we = 1'b1; cram_addr = 8'h22; cram_data = 16'h7FFF;
        @(negedge clk);
        total++;
        if (dut_word() !== 17'd0) begin
            bad++; $display("FAIL rst_clear: got %h want 0", dut_word());
        end
        rst = 1'b0; cram_we = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (dut_word() !== 17'd0) begin
                bad++; $display("FAIL rst_stale%0d: got %h want 0", k, dut_word());
            end
        end
        exp_col = '0; exp_hs = 1'b0; exp_vs = 1'b0;
        slot(8'h22, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, "post_rst");
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++)
            slot(8'($urandom), 1'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0),
                 1'($urandom), 1'($urandom), $sformatf("b2b%0d", i));
        drain();
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            repeat (4) begin
                @(negedge clk);
                vplex_in = 8'($urandom); hires = 1'($urandom); gpal = 4'($urandom);
                blank_in = 1'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            end
            total++;
            if (dut_word() !== {exp_col, exp_hs, exp_vs}) begin
                bad++;
                $display("FAIL hold%0d: got %h want %h", i, dut_word(), {exp_col, exp_hs, exp_vs});
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_blank_sync();
        test_same_clk_write();
        test_hires();
        test_mid_reset();
        test_back_to_back();
        test_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
